// File: rtl/lap_buffer.sv
// rtl/lap_buffer.sv - stopwatch lap capture buffer with recall display
//
// Purpose: stores up to DEPTH lap times taken from a live stopwatch. Each
// lap press captures the live time. Each recall press steps the display
// through the stored laps, from oldest to newest, and then returns to live
// time. A clear press empties the buffer.
//
// Ports:
//   clock, reset_n             system clock; asynchronous active-low reset
//   lap, recall, clear         debounced button levels, rising edge = event
//   hour, minute, second       live time, binary
//   m_sec                      live hundredths, 0..99
//   out_hour .. out_m_sec      displayed time, registered, 1-cycle latency
//   show_lap                   1 = a stored lap is displayed, 0 = live time
//   lap_index                  index of the displayed lap, 0 = oldest
//   lap_count                  number of stored laps
//   full, empty                lap_count == DEPTH / lap_count == 0
//   overflow                   sticky: a lap was dropped because buffer full
module lap_buffer #(
  parameter int DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       lap,
  input  logic                       recall,
  input  logic                       clear,
  input  logic [5:0]                 hour,
  input  logic [5:0]                 minute,
  input  logic [5:0]                 second,
  input  logic [6:0]                 m_sec,
  output logic [5:0]                 out_hour,
  output logic [5:0]                 out_minute,
  output logic [5:0]                 out_second,
  output logic [6:0]                 out_m_sec,
  output logic                       show_lap,
  output logic [$clog2(DEPTH)-1:0]   lap_index,
  output logic [$clog2(DEPTH):0]     lap_count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [IW:0] DEPTH_C = (IW+1)'(DEPTH);

  typedef enum logic {
    ST_LIVE   = 1'b0,
    ST_RECALL = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IW-1:0]   r_lap_index;
  logic [IW-1:0]   w_lap_index_nxt;
  logic [IW:0]     r_lap_count;
  logic [IW-1:0]   r_wr_ptr;
  logic            r_overflow;
  logic            r_lap_q;
  logic            r_recall_q;
  logic            r_clear_q;
  logic [24:0]     r_mem [DEPTH];
  logic [24:0]     r_out;

  logic            w_lap_ev;
  logic            w_recall_ev;
  logic            w_clear_ev;
  logic            w_full;
  logic            w_wr_en;
  logic [24:0]     w_live;
  logic [IW:0]     w_idx_inc;

  assign w_live      = {hour, minute, second, m_sec};
  assign w_lap_ev    = lap    & ~r_lap_q;
  assign w_recall_ev = recall & ~r_recall_q;
  assign w_clear_ev  = clear  & ~r_clear_q;
  assign w_full      = (r_lap_count == DEPTH_C);
  // Clear wins over a simultaneous lap press; a lap while full is dropped.
  assign w_wr_en     = w_lap_ev & ~w_clear_ev & ~w_full;
  assign w_idx_inc   = {1'b0, r_lap_index} + {{IW{1'b0}}, 1'b1};

  // Edge-detect copies reset to 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_lap_q    <= 1'b0;
      r_recall_q <= 1'b0;
      r_clear_q  <= 1'b0;
    end else begin
      r_lap_q    <= lap;
      r_recall_q <= recall;
      r_clear_q  <= clear;
    end
  end

  // Recall decisions use the lap_count held before this edge's lap write.
  always_comb begin
    w_state_nxt     = r_state;
    w_lap_index_nxt = r_lap_index;
    if (w_clear_ev) begin
      w_state_nxt     = ST_LIVE;
      w_lap_index_nxt = '0;
    end else if (w_recall_ev) begin
      case (r_state)
        ST_LIVE: begin
          if (r_lap_count != '0) begin
            w_state_nxt     = ST_RECALL;
            w_lap_index_nxt = '0;
          end
        end
        ST_RECALL: begin
          if (w_idx_inc < r_lap_count) begin
            w_lap_index_nxt = w_idx_inc[IW-1:0];
          end else begin
            w_state_nxt     = ST_LIVE;
            w_lap_index_nxt = '0;
          end
        end
        default: begin
          w_state_nxt     = ST_LIVE;
          w_lap_index_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_LIVE;
      r_lap_index <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_lap_index <= w_lap_index_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_lap_count <= '0;
      r_wr_ptr    <= '0;
      r_overflow  <= 1'b0;
    end else if (w_clear_ev) begin
      r_lap_count <= '0;
      r_wr_ptr    <= '0;
      r_overflow  <= 1'b0;
    end else if (w_lap_ev) begin
      if (w_full) begin
        r_overflow <= 1'b1;
      end else begin
        r_lap_count <= r_lap_count + 1'b1;
        r_wr_ptr    <= r_wr_ptr + 1'b1;
      end
    end
  end

  // Lap storage carries no reset; clear only rewinds the pointers.
  always_ff @(posedge clock) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= w_live;
    end
  end

  // Output mux follows the selection held before this edge, so a new
  // selection shows one edge after it is made. The written slot is never
  // the one on display, since lap_index < lap_count == wr_ptr.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_out <= '0;
    end else if (r_state == ST_RECALL) begin
      r_out <= r_mem[r_lap_index];
    end else begin
      r_out <= w_live;
    end
  end

  assign out_hour   = r_out[24:19];
  assign out_minute = r_out[18:13];
  assign out_second = r_out[12:7];
  assign out_m_sec  = r_out[6:0];
  assign show_lap   = (r_state == ST_RECALL);
  assign lap_index  = r_lap_index;
  assign lap_count  = r_lap_count;
  assign full       = w_full;
  assign empty      = (r_lap_count == '0);
  assign overflow   = r_overflow;

endmodule
